adder_seq: RTL and testbench

Multi-cycle sequencer that performs a wide add of two `3*CHUNKS`-bit operands by time-multiplexing a single instance of the team's 3-bit ripple `adder` (ports `a`, `b`, `cin`, `sum`, `cout`). Each cycle it feeds the adder one 3-bit chunk, least significant chunk first, and registers the chunk carry between cycles. A start/busy/done handshake lets a parent datapath issue adds without knowing the chunk count.

---
 rtl/adder_seq.sv | 233 +++++++++++++++++++++++
 tb/tb_adder_seq.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/adder_seq.sv
// -----------------------------------------------------------------------------
// adder_seq -- multi-cycle wide adder built around one 3-bit ripple adder.
//
// Adds two W = 3*CHUNKS bit operands plus a carry-in. One 3-bit chunk is added
// per cycle, least significant chunk first, and the chunk carry is registered
// between cycles. Result registers only change on the completing edge, so
// partial sums are never visible.
//
// Optional feature macro: ADDER_SEQ_OVF_EN
//   When defined, adds the `ovf` output (signed overflow of the last add).
//
// Modules in this file:
//   adder      3-bit ripple-carry adder (a, b, cin -> sum, cout)
//   adder_seq  top-level sequencer
//
// adder_seq ports:
//   clk       in   1   clock, rising edge
//   rst_n     in   1   synchronous active-low reset
//   start     in   1   request an add (accepted in IDLE or DONE)
//   a_in      in   W   operand A, sampled on accept
//   b_in      in   W   operand B, sampled on accept
//   cin_in    in   1   carry-in, sampled on accept
//   busy      out  1   high while chunks are being added (RUN)
//   done      out  1   one-cycle pulse, result valid (DONE)
//   sum_out   out  W   sum of the last completed add, held
//   cout_out  out  1   carry-out of the last completed add, held
//   ovf       out  1   signed overflow of the last add (ADDER_SEQ_OVF_EN only)
// -----------------------------------------------------------------------------

module adder (
  input  logic [2:0] a,
  input  logic [2:0] b,
  input  logic       cin,
  output logic [2:0] sum,
  output logic       cout
);

  logic [3:0] w_c;

  assign w_c[0] = cin;

  for (genvar i = 0; i < 3; i++) begin : g_fa
    assign sum[i]     = a[i] ^ b[i] ^ w_c[i];
    assign w_c[i + 1] = (a[i] & b[i]) | (w_c[i] & (a[i] ^ b[i]));
  end

  assign cout = w_c[3];

endmodule

module adder_seq #(
  parameter int CHUNKS = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [3*CHUNKS-1:0]   a_in,
  input  logic [3*CHUNKS-1:0]   b_in,
  input  logic                  cin_in,
  output logic                  busy,
  output logic                  done,
  output logic [3*CHUNKS-1:0]   sum_out,
  output logic                  cout_out
`ifdef ADDER_SEQ_OVF_EN
  ,
  output logic                  ovf
`endif
);

  localparam int W  = 3 * CHUNKS;
  localparam int IW = (CHUNKS > 1) ? $clog2(CHUNKS) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t r_state;
  state_t w_state_next;

  // Latched operands, running carry, chunk index and partial-sum accumulator.
  logic [W-1:0]  r_a;
  logic [W-1:0]  r_b;
  logic          r_carry;
  logic [IW-1:0] r_idx;
  logic [W-1:0]  r_acc;

  // Architectural result registers.
  logic [W-1:0]  r_sum_out;
  logic          r_cout_out;

  // Current chunk fed to the shared adder and what it produces.
  logic [2:0]    w_a_chunk;
  logic [2:0]    w_b_chunk;
  logic [2:0]    w_sum_chunk;
  logic          w_cout_chunk;

  logic [W-1:0]  w_acc_next;
  logic          w_last;
  logic          w_accept;

  // ---------------------------------------------------------------------------
  // Shared chunk adder
  // ---------------------------------------------------------------------------
  adder u_adder (
    .a    (w_a_chunk),
    .b    (w_b_chunk),
    .cin  (r_carry),
    .sum  (w_sum_chunk),
    .cout (w_cout_chunk)
  );

  // Chunk operand select. Kept separate from the accumulator merge below so
  // the adder output never feeds back into the block that drives its inputs.
  // NOTE: every variable written in always_comb gets a default first, so no
  // path through the block can leave it unassigned and infer a latch.
  always_comb begin
    w_a_chunk = '0;
    w_b_chunk = '0;
    for (int k = 0; k < CHUNKS; k++) begin
      if (r_idx == IW'(k)) begin
        w_a_chunk = r_a[3*k +: 3];
        w_b_chunk = r_b[3*k +: 3];
      end
    end
  end

  // Accumulator with the current chunk's sum merged in. On the last chunk this
  // is the complete result, which lets sum_out load on the same edge.
  always_comb begin
    w_acc_next = r_acc;
    for (int k = 0; k < CHUNKS; k++) begin
      if (r_idx == IW'(k)) begin
        w_acc_next[3*k +: 3] = w_sum_chunk;
      end
    end
  end

  assign w_last   = (r_idx == IW'(CHUNKS - 1));
  assign w_accept = start && ((r_state == S_IDLE) || (r_state == S_DONE));

  // ---------------------------------------------------------------------------
  // FSM
  // ---------------------------------------------------------------------------
  // NOTE: reset is synchronous: rst_n is only looked at on the rising edge, so
  // it is a plain data input to every flop and wins over start on that edge.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    busy         = 1'b0;
    done         = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start) w_state_next = S_RUN;
      end
      S_RUN: begin
        busy = 1'b1;
        // start is deliberately not looked at here.
        if (w_last) w_state_next = S_DONE;
      end
      S_DONE: begin
        done         = 1'b1;
        // The DONE cycle doubles as an accept cycle for back-to-back issue.
        w_state_next = start ? S_RUN : S_IDLE;
      end
      default: begin
        w_state_next = S_IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Datapath
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_a        <= '0;
      r_b        <= '0;
      r_carry    <= 1'b0;
      r_idx      <= '0;
      r_acc      <= '0;
      r_sum_out  <= '0;
      r_cout_out <= 1'b0;
    end else if (w_accept) begin
      r_a     <= a_in;
      r_b     <= b_in;
      r_carry <= cin_in;
      r_idx   <= '0;
    end else if (r_state == S_RUN) begin
      r_acc   <= w_acc_next;
      r_carry <= w_cout_chunk;
      r_idx   <= r_idx + 1'b1;
      if (w_last) begin
        r_sum_out  <= w_acc_next;
        r_cout_out <= w_cout_chunk;
      end
    end
  end

  assign sum_out  = r_sum_out;
  assign cout_out = r_cout_out;

`ifdef ADDER_SEQ_OVF_EN
  // ---------------------------------------------------------------------------
  // Signed overflow: operands agree in sign but the result does not.
  // ---------------------------------------------------------------------------
  logic r_ovf;
  logic w_ovf_next;

  assign w_ovf_next = (r_a[W-1] == r_b[W-1]) && (w_acc_next[W-1] != r_a[W-1]);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_ovf <= 1'b0;
    end else if (!w_accept && (r_state == S_RUN) && w_last) begin
      r_ovf <= w_ovf_next;
    end
  end

  assign ovf = r_ovf;
`endif

endmodule

// File: tb/tb_adder_seq.sv
// -----------------------------------------------------------------------------
// tb_adder_seq -- self-checking bench for adder_seq with CHUNKS = 4 (W = 12).
// Expected results are queued when an add is accepted and compared when done
// pulses. Compile with +define+ADDER_SEQ_OVF_EN to also check ovf.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

module tb_adder_seq;

  localparam int CHUNKS = 4;
  localparam int W      = 3 * CHUNKS;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start;
  logic [W-1:0] a_in;
  logic [W-1:0] b_in;
  logic         cin_in;
  logic         busy;
  logic         done;
  logic [W-1:0] sum_out;
  logic         cout_out;
`ifdef ADDER_SEQ_OVF_EN
  logic         ovf;
`endif

  always #5 clk = ~clk;

  adder_seq #(.CHUNKS(CHUNKS)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .a_in     (a_in),
    .b_in     (b_in),
    .cin_in   (cin_in),
    .busy     (busy),
    .done     (done),
    .sum_out  (sum_out),
    .cout_out (cout_out)
`ifdef ADDER_SEQ_OVF_EN
    ,
    .ovf      (ovf)
`endif
  );

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;
  } vec_t;

  typedef struct {
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;
  } exp_t;

  exp_t sb[$];

  int n_checks      = 0;
  int n_errors      = 0;
  int done_cnt      = 0;
  int cyc           = 0;
  int done_cyc_last = 0;
  int done_cyc_prev = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b, input logic c);
    exp_t       e;
    logic [W:0] s;
    s      = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, c};
    e.sum  = s[W-1:0];
    e.cout = s[W];
    e.ovf  = (a[W-1] == b[W-1]) && (s[W-1] != a[W-1]);
    return e;
  endfunction

  function automatic exp_t mk_exp(input logic [W-1:0] s, input logic c, input logic o);
    exp_t e;
    e.sum  = s;
    e.cout = c;
    e.ovf  = o;
    return e;
  endfunction

  always @(posedge clk) cyc++;

  // Scoreboard side: every done pulse must match the oldest pending add.
  always @(negedge clk) begin : mon
    exp_t e;
    if (done === 1'b1) begin
      done_cnt++;
      done_cyc_prev = done_cyc_last;
      done_cyc_last = cyc;
      if (sb.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL unexpected_done: got done=1 with no add pending (t=%0t)", $time);
      end else begin
        e = sb.pop_front();
        check("sum_out", 32'(sum_out), 32'(e.sum));
        check("cout_out", 32'(cout_out), 32'(e.cout));
`ifdef ADDER_SEQ_OVF_EN
        check("ovf", 32'(ovf), 32'(e.ovf));
`endif
      end
    end
  end

  // Drive one add; returns at the negedge right after the accepting edge.
  task automatic accept(input logic [W-1:0] a, input logic [W-1:0] b, input logic c,
                        input bit push, input exp_t e);
    @(negedge clk);
    start  = 1'b1;
    a_in   = a;
    b_in   = b;
    cin_in = c;
    @(negedge clk);
    start = 1'b0;
    if (push) sb.push_back(e);
  endtask

  // Bounded wait for done; counts cycles and busy cycles since the accept.
  task automatic wait_done(output int k, output int busy_n);
    k      = 0;
    busy_n = 0;
    while (done !== 1'b1 && k < 20) begin
      if (busy === 1'b1) busy_n++;
      @(negedge clk);
      k++;
    end
    #1;
  endtask

  vec_t vecs[7];

  initial begin
    int   k;
    int   bn;
    int   c0;
    exp_t e;
    logic [W-1:0] ra;
    logic [W-1:0] rb;
    logic         rc;

    vecs[0] = '{a: 12'hFFF, b: 12'h001, cin: 1'b0, sum: 12'h000, cout: 1'b1, ovf: 1'b0};
    vecs[1] = '{a: 12'h123, b: 12'h456, cin: 1'b1, sum: 12'h57A, cout: 1'b0, ovf: 1'b0};
    vecs[2] = '{a: 12'h7FF, b: 12'h001, cin: 1'b0, sum: 12'h800, cout: 1'b0, ovf: 1'b1};
    vecs[3] = '{a: 12'h800, b: 12'h800, cin: 1'b0, sum: 12'h000, cout: 1'b1, ovf: 1'b1};
    vecs[4] = '{a: 12'hFFF, b: 12'hFFF, cin: 1'b1, sum: 12'hFFF, cout: 1'b1, ovf: 1'b0};
    vecs[5] = '{a: 12'h000, b: 12'h000, cin: 1'b1, sum: 12'h001, cout: 1'b0, ovf: 1'b0};
    vecs[6] = '{a: 12'h555, b: 12'h2AA, cin: 1'b1, sum: 12'h800, cout: 1'b0, ovf: 1'b1};

    rst_n  = 1'b0;
    start  = 1'b0;
    a_in   = '0;
    b_in   = '0;
    cin_in = 1'b0;

    // Reset state.
    repeat (3) @(negedge clk);
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_done", 32'(done), 32'd0);
    check("reset_sum", 32'(sum_out), 32'd0);
    check("reset_cout", 32'(cout_out), 32'd0);
`ifdef ADDER_SEQ_OVF_EN
    check("reset_ovf", 32'(ovf), 32'd0);
`endif
    rst_n = 1'b1;

    // Table vectors: latency, busy length and results.
    for (int i = 0; i < 7; i++) begin
      accept(vecs[i].a, vecs[i].b, vecs[i].cin, 1'b1,
             mk_exp(vecs[i].sum, vecs[i].cout, vecs[i].ovf));
      wait_done(k, bn);
      check("latency", 32'(k), 32'd4);
      check("busy_cycles", 32'(bn), 32'd4);
      check("busy_at_done", 32'(busy), 32'd0);
    end

    // Random vectors against the arithmetic model.
    for (int i = 0; i < 6; i++) begin
      ra = W'($urandom_range(0, (1 << W) - 1));
      rb = W'($urandom_range(0, (1 << W) - 1));
      rc = 1'($urandom_range(0, 1));
      accept(ra, rb, rc, 1'b1, model(ra, rb, rc));
      wait_done(k, bn);
      check("rand_latency", 32'(k), 32'd4);
    end

    // start during RUN is ignored.
    c0 = done_cnt;
    accept(12'h001, 12'h001, 1'b0, 1'b1, mk_exp(12'h002, 1'b0, 1'b0));
    @(negedge clk);
    start  = 1'b1;
    a_in   = 12'hFFF;
    b_in   = 12'hFFF;
    cin_in = 1'b0;
    @(negedge clk);
    start = 1'b0;
    wait_done(k, bn);
    repeat (8) @(negedge clk);
    #1;
    check("ignored_start_done_pulses", 32'(done_cnt - c0), 32'd1);
    check("ignored_start_busy_idle", 32'(busy), 32'd0);

    // Back-to-back issue with start held high.
    c0 = done_cnt;
    @(negedge clk);
    start  = 1'b1;
    a_in   = 12'h010;
    b_in   = 12'h020;
    cin_in = 1'b0;
    @(negedge clk);
    sb.push_back(mk_exp(12'h030, 1'b0, 1'b0));
    a_in = 12'h100;
    b_in = 12'h200;
    wait_done(k, bn);
    check("b2b_first_latency", 32'(k), 32'd4);
    @(negedge clk);
    start = 1'b0;
    sb.push_back(mk_exp(12'h300, 1'b0, 1'b0));
    check("b2b_busy_after_done", 32'(busy), 32'd1);
    wait_done(k, bn);
    check("b2b_pulses", 32'(done_cnt - c0), 32'd2);
    check("b2b_spacing", 32'(done_cyc_last - done_cyc_prev), 32'd5);

    // Reset in the middle of RUN aborts the add; reset wins over start.
    c0 = done_cnt;
    accept(12'h555, 12'h0AA, 1'b1, 1'b0, mk_exp('0, 1'b0, 1'b0));
    @(negedge clk);
    check("run_holds_sum", 32'(sum_out), 32'h300);
    rst_n = 1'b0;
    start = 1'b1;
    @(negedge clk);
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_done", 32'(done), 32'd0);
    check("midrst_sum", 32'(sum_out), 32'd0);
    check("midrst_cout", 32'(cout_out), 32'd0);
    rst_n = 1'b1;
    start = 1'b0;
    repeat (8) @(negedge clk);
    #1;
    check("midrst_no_done", 32'(done_cnt - c0), 32'd0);
    check("midrst_idle", 32'(busy), 32'd0);

    accept(12'h0F0, 12'h00F, 1'b0, 1'b1, mk_exp(12'h0FF, 1'b0, 1'b0));
    wait_done(k, bn);
    check("post_rst_latency", 32'(k), 32'd4);

    repeat (3) @(negedge clk);
    check("scoreboard_drained", 32'(sb.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish by t=%0t required completion", $time);
    $fatal(1, "watchdog");
  end

endmodule
